// File: rtl/cordic_prerot.sv
// Vectoring-CORDIC input stage: sign-extend, pre-rotate by +/-90 deg so x >= 0, and seed z.
// Two enabled edges to xo/yo/zo/vo, pipelen more to valid_end; never stalls except via ena.
module cordic_prerot #(
    parameter int width   = 16,
    parameter int awidth  = 20,
    parameter int pipelen = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              din_valid,
    input  logic [width-3:0]  din_x,
    input  logic [width-3:0]  din_y,
    output logic [width-1:0]  xo,
    output logic [width-1:0]  yo,
    output logic [awidth-1:0] zo,
    output logic              vo,
    output logic              valid_end
);

    localparam logic [awidth-1:0] Z_P90 = {2'b01, {(awidth-2){1'b0}}};
    localparam logic [awidth-1:0] Z_M90 = {2'b11, {(awidth-2){1'b0}}};

    logic [width-1:0]  x1_q, y1_q, x1_d, y1_d;
    logic              v1_q;
    logic [width-1:0]  xo_q, yo_q, xo_d, yo_d;
    logic [awidth-1:0] zo_q, zo_d;
    logic              vo_q;

    assign x1_d = {{2{din_x[width-3]}}, din_x};
    assign y1_d = {{2{din_y[width-3]}}, din_y};

    // Only the signs steer the rotation; -2^(width-3) still fits after negation.
    always_comb begin
        xo_d = x1_q;
        yo_d = y1_q;
        zo_d = '0;
        if (x1_q[width-1]) begin
            if (!y1_q[width-1]) begin
                xo_d = y1_q;
                yo_d = -x1_q;
                zo_d = Z_P90;
            end else begin
                xo_d = -y1_q;
                yo_d = x1_q;
                zo_d = Z_M90;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            y1_q <= '0;
            v1_q <= 1'b0;
            xo_q <= '0;
            yo_q <= '0;
            zo_q <= '0;
            vo_q <= 1'b0;
        end else if (ena) begin
            x1_q <= x1_d;
            y1_q <= y1_d;
            v1_q <= din_valid;
            xo_q <= xo_d;
            yo_q <= yo_d;
            zo_q <= zo_d;
            vo_q <= v1_q;
        end
    end

    assign xo = xo_q;
    assign yo = yo_q;
    assign zo = zo_q;
    assign vo = vo_q;

    // Valid delay line matching the downstream iteration chain.
    generate
        if (pipelen == 0) begin : g_nodelay
            assign valid_end = vo_q;
        end else begin : g_delay
            logic [pipelen-1:0] dl_q, dl_d;

            always_comb begin
                dl_d    = dl_q << 1;
                dl_d[0] = vo_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dl_q <= '0;
                end else if (ena) begin
                    dl_q <= dl_d;
                end
            end

            assign valid_end = dl_q[pipelen-1];
        end
    endgenerate

endmodule

// File: tb/tb_cordic_prerot.sv
// Scoreboard bench for cordic_prerot: expected outputs queued at drive time, checked per edge.
module tb_cordic_prerot;

    localparam int W  = 16;
    localparam int AW = 20;
    localparam int PL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          din_valid = 1'b0;
    logic [W-3:0]  din_x = '0;
    logic [W-3:0]  din_y = '0;
    logic [W-1:0]  xo, yo;
    logic [AW-1:0] zo;
    logic          vo, valid_end;

    cordic_prerot #(.width(W), .awidth(AW), .pipelen(PL)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .din_valid (din_valid),
        .din_x     (din_x),
        .din_y     (din_y),
        .xo        (xo),
        .yo        (yo),
        .zo        (zo),
        .vo        (vo),
        .valid_end (valid_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int z;
        int due;
    } exp_t;

    exp_t q[$];
    int   vq[$];
    int   checks = 0;
    int   errors = 0;
    int   en_edges = 0;
    int   ve_cnt = 0;
    exp_t held;
    logic held_vo = 1'b0;
    logic held_ve = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int due);
        exp_t e;
        e.due = due;
        if (x >= 0) begin
            e.x = x;  e.y = y;  e.z = 0;
        end else if (y >= 0) begin
            e.x = y;  e.y = -x; e.z = 262144;
        end else begin
            e.x = -y; e.y = x;  e.z = 786432;
        end
        return e;
    endfunction

    task automatic check_data(input string tag, input exp_t e);
        chk({tag, "_xo"}, int'($signed(xo)), e.x);
        chk({tag, "_yo"}, int'($signed(yo)), e.y);
        chk({tag, "_zo"}, int'(zo), e.z);
    endtask

    // One clock: drive at negedge, clock it, check at the next negedge.
    task automatic step(input logic r, input logic e, input logic v, input int x, input int y);
        logic exp_vo, exp_ve;
        rst       = r;
        ena       = e;
        din_valid = v;
        din_x     = x[W-3:0];
        din_y     = y[W-3:0];
        if (!r && e && v) begin
            q.push_back(model(x, y, en_edges + 2));
            vq.push_back(en_edges + 2 + PL);
        end
        @(posedge clk);
        if (e) en_edges++;
        @(negedge clk);
        if (r) begin
            q.delete();
            vq.delete();
            chk("rst_xo", int'(xo), 0);
            chk("rst_yo", int'(yo), 0);
            chk("rst_zo", int'(zo), 0);
            chk("rst_vo", int'(vo), 0);
            chk("rst_ve", int'(valid_end), 0);
            held_vo = 1'b0;
            held_ve = 1'b0;
        end else if (e) begin
            exp_vo = (q.size() > 0) && (q[0].due == en_edges);
            chk("vo", int'(vo), int'(exp_vo));
            if (exp_vo) begin
                held = q.pop_front();
                check_data("out", held);
            end
            exp_ve = (vq.size() > 0) && (vq[0] == en_edges);
            chk("valid_end", int'(valid_end), int'(exp_ve));
            if (exp_ve) void'(vq.pop_front());
            if (valid_end) ve_cnt++;
            held_vo = exp_vo;
            held_ve = exp_ve;
        end else begin
            chk("hold_vo", int'(vo), int'(held_vo));
            chk("hold_ve", int'(valid_end), int'(held_ve));
            if (held_vo) check_data("hold", held);
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    initial begin
        @(negedge clk);
        // Reset with random inputs and ena high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, rnd(), rnd());
        step(1'b0, 1'b1, 1'b1, 100, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);

        // Quadrants and boundaries
        step(1'b0, 1'b1, 1'b1, -100, 50);
        step(1'b0, 1'b1, 1'b1, -100, -50);
        step(1'b0, 1'b1, 1'b1, 0, -7);
        step(1'b0, 1'b1, 1'b1, -8192, 0);
        step(1'b0, 1'b1, 1'b1, -8192, -8192);
        step(1'b0, 1'b1, 1'b1, 8191, 8191);
        step(1'b0, 1'b1, 1'b0, -5, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Enable gating mid-stream
        step(1'b0, 1'b1, 1'b1, 11, -22);
        step(1'b0, 1'b1, 1'b1, -33, 44);
        step(1'b0, 1'b1, 1'b1, -55, -66);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, rnd(), rnd());
        step(1'b0, 1'b1, 1'b1, 77, 88);
        step(1'b0, 1'b1, 1'b1, -99, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < PL + 2; i++) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Single pulse through the delay line, then one killed by reset
        step(1'b0, 1'b1, 1'b1, 5, 5);
        for (int i = 0; i < PL + 4; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, -5, 5);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        ve_cnt = 0;
        for (int i = 0; i < PL + 4; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("killed_pulse", ve_cnt, 0);

        // Throughput
        ve_cnt = 0;
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b1, rnd(), rnd());
        for (int i = 0; i < PL + 4; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        chk("ve_count", ve_cnt, 1000);
        chk("drain_q", q.size(), 0);
        chk("drain_vq", vq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
